// File: rtl/uart_beacon.sv
// Periodic / triggered UART frame generator: MESSAGE, space, hex sequence number, optional CR, LF.
// Drives a uart_tx byte interface and queues one request that arrives while a frame is in flight.
module uart_beacon #(
    parameter int                   PERIOD_CYCLES = 12_000_000,
    parameter int                   MSG_LEN       = 5,
    parameter logic [8*MSG_LEN-1:0] MESSAGE       = "HELLO",
    parameter int                   SEQ_DIGITS    = 4,
    parameter int                   ADD_CR        = 1,
    parameter int                   BUSY_TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    trigger,
    output logic [7:0]              tx_data,
    output logic                    tx_data_valid,
    input  logic                    tx_busy,
    output logic                    sending,
    output logic [4*SEQ_DIGITS-1:0] seq_count,
    output logic                    heartbeat,
    output logic                    dropped,
    output logic                    tx_timeout,
    output logic [1:0]              state_dbg,
    output logic                    pending_dbg
);

    localparam int FL      = MSG_LEN + 1 + SEQ_DIGITS + ADD_CR + 1;
    localparam int IDX_W   = $clog2(FL);
    localparam int TIMER_W = $clog2(PERIOD_CYCLES);
    localparam int TMO_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam int SEQ_W   = 4 * SEQ_DIGITS;

    // Handshake: tx_data_valid is a one-cycle strobe issued only while tx_busy is low;
    // tx_busy rising afterwards means uart_tx accepted the byte, tx_busy falling means it is done.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SEQ_W-1:0]   seq_count_q;
    logic [SEQ_W-1:0]   seq_lat_q;
    logic [TIMER_W-1:0] timer_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [7:0]         tx_data_q;
    logic               tx_data_valid_q;
    logic               sending_q;
    logic               pending_q;
    logic               heartbeat_q;
    logic               dropped_q;
    logic               tx_timeout_q;

    logic               expiry_d;
    logic               req_d;
    logic               busy_tmo_d;
    logic               byte_done_d;
    logic               last_byte_d;
    logic [7:0]         cur_byte_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    assign expiry_d    = enable && (timer_q == TIMER_W'(PERIOD_CYCLES - 1));
    assign req_d       = trigger || expiry_d;
    assign busy_tmo_d  = (state_q == WAIT_BUSY) && !tx_busy && (tmo_q == TMO_W'(BUSY_TIMEOUT - 1));
    assign byte_done_d = busy_tmo_d || ((state_q == WAIT_IDLE) && !tx_busy);
    assign last_byte_d = (idx_q == IDX_W'(FL - 1));

    // Byte selection by frame position; LF is the fallback for the final slot.
    always_comb begin
        cur_byte_d = 8'h0A;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (int'(idx_q) == k) cur_byte_d = MESSAGE[8*(MSG_LEN-1-k) +: 8];
        end
        if (int'(idx_q) == MSG_LEN) cur_byte_d = 8'h20;
        for (int k = 0; k < SEQ_DIGITS; k++) begin
            if (int'(idx_q) == MSG_LEN + 1 + k) cur_byte_d = hex_ascii(seq_lat_q[4*(SEQ_DIGITS-1-k) +: 4]);
        end
        if ((ADD_CR != 0) && (int'(idx_q) == MSG_LEN + 1 + SEQ_DIGITS)) cur_byte_d = 8'h0D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            seq_count_q     <= '0;
            seq_lat_q       <= '0;
            timer_q         <= '0;
            tmo_q           <= '0;
            tx_data_q       <= '0;
            tx_data_valid_q <= 1'b0;
            sending_q       <= 1'b0;
            pending_q       <= 1'b0;
            heartbeat_q     <= 1'b0;
            dropped_q       <= 1'b0;
            tx_timeout_q    <= 1'b0;
        end else begin
            tx_data_valid_q <= 1'b0;

            // Timer keeps running through frames so the period never drifts.
            if (!enable) begin
                timer_q <= '0;
            end else if (expiry_d) begin
                timer_q     <= '0;
                heartbeat_q <= ~heartbeat_q;
            end else begin
                timer_q <= timer_q + TIMER_W'(1);
            end

            if (sending_q && req_d) begin
                if (pending_q) dropped_q <= 1'b1;
                else           pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (req_d || pending_q) begin
                        idx_q     <= '0;
                        seq_lat_q <= seq_count_q;
                        // A fresh request arriving while a queued one is consumed stays queued.
                        pending_q <= pending_q && req_d;
                        sending_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!tx_busy) begin
                        tx_data_q       <= cur_byte_d;
                        tx_data_valid_q <= 1'b1;
                        tmo_q           <= '0;
                        state_q         <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy)          state_q      <= WAIT_IDLE;
                    else if (busy_tmo_d)  tx_timeout_q <= 1'b1;
                    else                  tmo_q        <= tmo_q + TMO_W'(1);
                end
                default: ;
            endcase

            if (byte_done_d) begin
                if (last_byte_d) begin
                    sending_q   <= 1'b0;
                    seq_count_q <= seq_count_q + SEQ_W'(1);
                    state_q     <= IDLE;
                end else begin
                    idx_q   <= idx_q + IDX_W'(1);
                    state_q <= ISSUE;
                end
            end
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_data_valid_q;
    assign sending       = sending_q;
    assign seq_count     = seq_count_q;
    assign heartbeat     = heartbeat_q;
    assign dropped       = dropped_q;
    assign tx_timeout    = tx_timeout_q;
    assign state_dbg     = state_q;
    assign pending_dbg   = pending_q;

endmodule

// File: doc/uart_beacon.md
# uart_beacon

Parametrised periodic UART message generator that drives the codebase's `uart_tx` byte interface. On every period expiry or external trigger it emits one frame: a fixed parameter string, a space, an uppercase-hex sequence number, optional CR, and LF. It replaces hard-coded per-board message logic in top-level designs, and adds queuing of requests that arrive mid-frame.

## Interface
- `PERIOD_CYCLES`, 12_000_000: clock cycles between periodic requests; must be ≥ 2.
- `MSG_LEN`, 5: number of characters in `MESSAGE`; must be ≥ 1.
- `MESSAGE`, "HELLO": packed 8*MSG_LEN-bit string; the first character is in the MSBs.
- `SEQ_DIGITS`, 4: number of hex digits of the sequence counter; range 1..8.
- `ADD_CR`, 1: 1 = emit 0x0D before 0x0A.
- `BUSY_TIMEOUT`, 15: maximum number of cycles to wait for `tx_busy` to rise after an issue.

- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: 1 = periodic timer runs; 0 = timer held at 0.
- `trigger`  in  1: 1-cycle pulse requests an immediate frame.
- `tx_data`  out  8: byte to `uart_tx`.
- `tx_data_valid`  out  1: 1-cycle issue strobe to `uart_tx`.
- `tx_busy`  in  1: busy output of `uart_tx`.
- `sending`  out  1: high from frame start until after the last byte completes.
- `seq_count`  out  4*SEQ_DIGITS: sequence number of the next frame.
- `heartbeat`  out  1: toggles on each period expiry.
- `dropped`  out  1: sticky flag; a request was lost.
- `tx_timeout`  out  1: sticky flag; `tx_busy` never rose after an issue.

## Operation
- Frame length is FL = MSG_LEN + 1 + SEQ_DIGITS + ADD_CR + 1 bytes.
- Byte order:
  - `MESSAGE` characters, first to last.
  - 0x20 (space).
  - `seq_count` digits, most significant first. Digit 0–9 maps to 0x30–0x39; digit A–F maps to 0x41–0x46.
  - 0x0D, only if `ADD_CR` = 1.
  - 0x0A.
- `seq_count` is captured at frame start. It increments by 1 after the LF completes and wraps from all-ones to 0.
- Timer:
  - When `enable` = 1, counts 0..PERIOD_CYCLES-1.
  - At PERIOD_CYCLES-1 it returns to 0, raises a request, and toggles `heartbeat`.
  - The timer runs during frames as well, so the period does not drift.
- Request = `trigger` OR timer expiry. Simultaneous sources in one cycle count as a single request.
- Request handling:
  - In IDLE: start a frame.
  - While `sending` with `pending` = 0: set `pending`.
  - While `sending` with `pending` = 1: set `dropped`.
- FSM states:
  - IDLE: on request or `pending`, load the byte index with 0, latch `seq_count`, clear `pending`, set `sending`, go to ISSUE.
  - ISSUE: when `tx_busy` = 0, drive `tx_data` = current byte and `tx_data_valid` = 1 for one cycle, go to WAIT_BUSY. While `tx_busy` = 1, hold in ISSUE.
  - WAIT_BUSY: on `tx_busy` = 1, go to WAIT_IDLE. After BUSY_TIMEOUT cycles without it, set `tx_timeout` and treat the byte as sent.
  - WAIT_IDLE: on `tx_busy` = 0:
    - If the byte index is FL-1, clear `sending`, increment `seq_count`, go to IDLE.
    - Otherwise, increment the byte index and go to ISSUE.
- With `enable` = 0, `trigger` still works and a frame in progress completes.
- Reset values:
  - `tx_data` = 0, `tx_data_valid` = 0, `sending` = 0, `seq_count` = 0.
  - `heartbeat` = 0, `dropped` = 0, `tx_timeout` = 0.
  - Timer = 0, `pending` = 0, state = IDLE.
- `rst` asserted mid-frame aborts the frame with no further strobes. `dropped` and `tx_timeout` are cleared only by `rst`.

## Timing
- All outputs are registered.
- Request sampled at edge k, with the block IDLE and `tx_busy` = 0: `tx_data_valid` is high in the cycle after edge k+1.
- `tx_data` is valid in the same cycle as `tx_data_valid` and holds until the next issue.
- Exactly one strobe per byte. No strobe is ever issued while `tx_busy` = 1.
- Inter-byte gap with an ideal `uart_tx`: 2 cycles from `tx_busy` falling to the next strobe.
- A pending frame starts 1 cycle after `sending` falls; `sending` goes low for exactly 1 cycle between the two frames.
- First timer expiry occurs PERIOD_CYCLES cycles after `rst` is released with `enable` = 1.

## Test plan
Configuration unless stated: PERIOD_CYCLES=100, MESSAGE="HI", MSG_LEN=2, SEQ_DIGITS=2, ADD_CR=0. The `uart_tx` model raises `tx_busy` 1 cycle after a strobe and holds it for 10 cycles.

- Periodic frames: `enable` = 1, no trigger → bytes 48 49 20 30 30 0A, then one period later 48 49 20 30 31 0A. `heartbeat` toggles every 100 cycles.
- Sequence wrap: force `seq_count` to FF → frame ends "FF\n"; next frame carries "00".
- Queuing: `trigger` mid-frame → second frame starts with `sending` low for exactly 1 cycle between frames. A second `trigger` in the same frame sets `dropped` = 1, and only 2 frames are sent.
- Simultaneous events: `trigger` in the same cycle as timer expiry, block IDLE → one frame, `pending` = 0, `dropped` = 0.
- Stuck UART: `tx_busy` held at 0 → `tx_timeout` = 1 and all 6 strobes still occur. `tx_busy` held at 1 → no strobe is issued.
- Reset and enable: `rst` mid-frame → the next cycle shows `tx_data_valid` = 0, all outputs at reset values, and no further bytes. `enable` = 0 with `trigger` → exactly one frame and `heartbeat` static.
